// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, taken-branch flushes,
// halt drain, and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_halt,
  input  logic             ex_ld,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             wb_halt,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_nop,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;

  state_t     state;
  logic [3:0] scnt;
  logic       hazard;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    hazard = ex_ld && (ex_rd != 5'd0) &&
             ((id_uses_rs1 && (ex_rd == id_rs1)) || (id_uses_rs2 && (ex_rd == id_rs2)));
  end

  // Control outputs act in the same cycle; reset forces a frozen, bubbling pipeline.
  always_comb begin
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_nop   = 1'b0;
    if (reset) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_nop   = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            ifid_flush = 1'b1;
            idex_nop   = 1'b1;
          end else if (hazard) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_nop   = 1'b1;
          end else if (id_halt) begin
            pc_write   = 1'b0;
            ifid_flush = 1'b1;
          end
        end
        STALL: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_nop   = 1'b1;
        end
        default: begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          ifid_flush = 1'b1;
          idex_nop   = 1'b1;
        end
      endcase
    end
  end

  assign halted = (state == HALTED);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RUN;
      scnt         <= 4'd0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            flush_count <= sat_inc(flush_count);
          end else if (hazard) begin
            stall_cycles <= sat_inc(stall_cycles);
            if (LOAD_STALL_CYCLES > 1) begin
              state <= STALL;
              scnt  <= 4'(LOAD_STALL_CYCLES - 1);
            end
          end else if (id_halt) begin
            state <= DRAIN;
          end
        end
        STALL: begin
          stall_cycles <= sat_inc(stall_cycles);
          scnt         <= scnt - 4'd1;
          if (scnt == 4'd1) state <= RUN;
        end
        DRAIN: begin
          if (wb_halt) state <= HALTED;
        end
        default: begin
          state <= HALTED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (default, and 3-cycle stall with 4-bit counters).
module tb_hazard_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       a_reset, a_uses1, a_uses2, a_idh, a_exld, a_br, a_wbh;
  logic [4:0] a_rs1, a_rs2, a_rd;
  logic       a_pc, a_ifw, a_fl, a_nop, a_h;
  logic [31:0] a_stall, a_flush;

  logic       b_reset, b_uses1, b_uses2, b_idh, b_exld, b_br, b_wbh;
  logic [4:0] b_rs1, b_rs2, b_rd;
  logic       b_pc, b_ifw, b_fl, b_nop, b_h;
  logic [3:0] b_stall, b_flush;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) dut_a (
    .clock(clock), .reset(a_reset), .id_rs1(a_rs1), .id_rs2(a_rs2),
    .id_uses_rs1(a_uses1), .id_uses_rs2(a_uses2), .id_halt(a_idh), .ex_ld(a_exld),
    .ex_rd(a_rd), .branch_taken(a_br), .wb_halt(a_wbh), .pc_write(a_pc),
    .ifid_write(a_ifw), .ifid_flush(a_fl), .idex_nop(a_nop), .halted(a_h),
    .stall_cycles(a_stall), .flush_count(a_flush)
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(4)) dut_b (
    .clock(clock), .reset(b_reset), .id_rs1(b_rs1), .id_rs2(b_rs2),
    .id_uses_rs1(b_uses1), .id_uses_rs2(b_uses2), .id_halt(b_idh), .ex_ld(b_exld),
    .ex_rd(b_rd), .branch_taken(b_br), .wb_halt(b_wbh), .pc_write(b_pc),
    .ifid_write(b_ifw), .ifid_flush(b_fl), .idex_nop(b_nop), .halted(b_h),
    .stall_cycles(b_stall), .flush_count(b_flush)
  );

  typedef struct {
    bit          sel;
    string       name;
    logic [68:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic step(input bit sel, input string name, input logic rst, input logic br,
                      input logic idh, input logic wbh, input logic exld, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                      input logic [3:0] ctl, input logic h, input int s, input int f);
    exp_t e;
    @(posedge clock);
    #1;
    {a_reset, a_br, a_idh, a_wbh, a_exld, a_rd, a_rs1, a_rs2, a_uses1, a_uses2} = '0;
    {b_reset, b_br, b_idh, b_wbh, b_exld, b_rd, b_rs1, b_rs2, b_uses1, b_uses2} = '0;
    if (!sel) begin
      a_reset = rst; a_br = br; a_idh = idh; a_wbh = wbh; a_exld = exld;
      a_rd = rd; a_rs1 = rs1; a_rs2 = rs2; a_uses1 = u1; a_uses2 = u2;
    end else begin
      b_reset = rst; b_br = br; b_idh = idh; b_wbh = wbh; b_exld = exld;
      b_rd = rd; b_rs1 = rs1; b_rs2 = rs2; b_uses1 = u1; b_uses2 = u2;
    end
    e.sel  = sel;
    e.name = name;
    e.exp  = {ctl, h, 32'(s), 32'(f)};
    q.push_back(e);
  endtask

  // Monitor: compare once per cycle, mid-cycle, against whatever the stimulus queued.
  initial begin
    exp_t        e;
    logic [68:0] act;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel) act = {b_pc, b_ifw, b_fl, b_nop, b_h, 28'd0, b_stall, 28'd0, b_flush};
        else       act = {a_pc, a_ifw, a_fl, a_nop, a_h, a_stall, a_flush};
        n_checks++;
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (pc,ifw,flush,nop,halted|stall|flush)",
                      e.name, act, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    {a_br, a_idh, a_wbh, a_exld, a_rd, a_rs1, a_rs2, a_uses1, a_uses2} = '0;
    {b_br, b_idh, b_wbh, b_exld, b_rd, b_rs1, b_rs2, b_uses1, b_uses2} = '0;
    a_reset = 1'b1;
    b_reset = 1'b1;
    repeat (2) @(posedge clock);

    // Instance A: single-bubble load-use, branch priority, halt drain
    //    sel name            rst br idh wbh ld rd  rs1 rs2 u1 u2 ctl     h  s  f
    step(0, "A_reset_forced", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 0, 0, 0);
    step(0, "A_run_idle",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 0, 0);
    step(0, "A_hazard_rs1",   0, 0, 0, 0, 1, 5, 5, 0, 1, 0, 4'b0001, 0, 0, 0);
    step(0, "A_after_stall",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 1, 0);
    step(0, "A_rd_zero",      0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 4'b1100, 0, 1, 0);
    step(0, "A_rs1_unused",   0, 0, 0, 0, 1, 5, 5, 0, 0, 0, 4'b1100, 0, 1, 0);
    step(0, "A_hazard_rs2",   0, 0, 0, 0, 1, 7, 0, 7, 0, 1, 4'b0001, 0, 1, 0);
    step(0, "A_branch_prio",  0, 1, 1, 0, 1, 5, 5, 0, 1, 0, 4'b1111, 0, 2, 0);
    step(0, "A_after_branch", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 2, 1);
    step(0, "A_halt_N",       0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b0110, 0, 2, 1);
    step(0, "A_drain_ignore", 0, 1, 0, 0, 1, 5, 5, 0, 1, 0, 4'b0011, 0, 2, 1);
    step(0, "A_drain_N2",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 0, 2, 1);
    step(0, "A_wb_halt_N3",   0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0011, 0, 2, 1);
    step(0, "A_halted_N4",    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 1, 2, 1);
    step(0, "A_halted_held",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 1, 2, 1);
    step(0, "A_reset_halted", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 1, 2, 1);
    step(0, "A_post_reset",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 0, 0);

    // Instance B: three-bubble stall, reset mid-stall, 4-bit saturation
    step(1, "B_reset",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 0, 0, 0);
    step(1, "B_hazard",       0, 0, 0, 0, 1, 9, 9, 0, 1, 0, 4'b0001, 0, 0, 0);
    step(1, "B_stall2_br",    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 1, 0);
    step(1, "B_stall3",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 2, 0);
    step(1, "B_back_run",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 3, 0);
    step(1, "B_hazard2",      0, 0, 0, 0, 1, 3, 0, 3, 0, 1, 4'b0001, 0, 3, 0);
    step(1, "B_stall_2nd",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0001, 0, 4, 0);
    step(1, "B_reset_stall",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0011, 0, 5, 0);
    step(1, "B_run_cleared",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 0, 0);
    for (int k = 0; k < 20; k++)
      step(1, $sformatf("B_flush_%0d", k), 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1111, 0, 0,
           (k > 15) ? 15 : k);
    step(1, "B_flush_sat",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 0, 0, 15);

    repeat (3) @(posedge clock);
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_queue: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
